// File: rtl/rf_pkg.sv
// Shared register-file definitions for the writeback path.
//   XLEN        : integer register width
//   REG_ADDR_W  : register index width
//   NREGS       : number of architectural integer registers
//   wb_entry_t  : one pending writeback {rd, data}
package rf_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO holding pending long-latency writebacks.
//   clk, rst   : clock, synchronous active-high reset (contents discarded)
//   push       : write push_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   push_data  : entry to store
//   head       : oldest stored entry (valid when !empty)
//   full/empty : occupancy flags derived from the registered count
//   count      : number of stored entries
module wb_fifo #(
  parameter  int W     = 69,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter owning the register-file write port. Merges one-cycle
// ALU results with buffered long-latency results and tracks outstanding
// long-latency destinations in a scoreboard.
//   alu_valid/alu_rd/alu_data : ALU result; alu_stall = not taken this cycle
//   mem_valid/mem_rd/mem_data : long-latency result, accepted when mem_ready
//   issue_valid/issue_rd      : long-latency op issued, marks rd busy
//   busy                      : bit i set while a write to xi is pending
//   reg_w/data_in/en_write    : registered RF write port
module wb_write_arbiter
  import rf_pkg::*;
#(
  parameter int N      = XLEN,
  parameter int DEPTH  = 2,
  parameter int STARVE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [N-1:0]          alu_data,
  output logic                  alu_stall,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [N-1:0]          mem_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [NREGS-1:0]      busy,
  output logic [REG_ADDR_W-1:0] reg_w,
  output logic [N-1:0]          data_in,
  output logic                  en_write
);

  localparam int W  = REG_ADDR_W + N;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE + 1);

  logic [W-1:0]          fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_push;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [N-1:0]          head_data;

  logic [SW-1:0]         starve_cnt;
  logic                  alu_req;
  logic                  buf_win;
  logic                  alu_win;
  logic [NREGS-1:0]      busy_next;

  assign head_rd   = fifo_head[W-1 -: REG_ADDR_W];
  assign head_data = fifo_head[N-1:0];

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot for a push.
  assign mem_ready = (fifo_count < CW'(DEPTH));
  // rd==0 completes the handshake but is never stored.
  assign fifo_push = mem_valid && !fifo_full && (mem_rd != '0);

  wb_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (buf_win),
    .push_data ({mem_rd, mem_data}),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    alu_req   = alu_valid && (alu_rd != '0);
    buf_win   = !fifo_empty && (!alu_req || (starve_cnt == SW'(STARVE)));
    alu_win   = alu_req && !buf_win;
    alu_stall = alu_req && buf_win;

    // Clear for the popped head first so a same-index issue overrides it.
    busy_next = busy;
    if (buf_win) busy_next[head_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_write   <= 1'b0;
      reg_w      <= '0;
      data_in    <= '0;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      en_write <= buf_win || alu_win;
      if (buf_win) begin
        reg_w   <= head_rd;
        data_in <= head_data;
      end else if (alu_win) begin
        reg_w   <= alu_rd;
        data_in <= alu_data;
      end

      if (alu_win && !fifo_empty) begin
        if (starve_cnt != SW'(STARVE)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end

      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
  import rf_pkg::*;

  localparam int N      = 64;
  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [N-1:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [N-1:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic [4:0]  reg_w;
  logic [N-1:0] data_in;
  logic        en_write;

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .N      (N),
    .DEPTH  (DEPTH),
    .STARVE (STARVE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .reg_w       (reg_w),
    .data_in     (data_in),
    .en_write    (en_write)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending results as a plain queue, a count of
  // consecutive lost arbitrations, and a busy bit per register.
  wb_entry_t   q[$];
  int          lost;
  logic [31:0] m_busy;
  logic        m_en;
  logic [4:0]  m_rd;
  logic [63:0] m_data;

  // Combinational outputs sampled mid-cycle by the last step.
  logic s_stall;
  logic s_ready;

  task automatic step(input logic r, input logic av, input logic [4:0] ard,
                      input logic [63:0] ad, input logic mv, input logic [4:0] mrd,
                      input logic [63:0] md, input logic iv, input logic [4:0] ird,
                      input bit use_model);
    wb_entry_t e;
    bit areq, bturn, e_ready, e_stall;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    issue_valid = iv; issue_rd = ird;
    @(negedge clk);
    s_stall = alu_stall;
    s_ready = mem_ready;
    e_ready = (q.size() < DEPTH);
    areq    = av && (ard != 0);
    bturn   = (q.size() > 0) && (!areq || lost == STARVE);
    e_stall = areq && bturn;
    if (use_model) begin
      chk("model alu_stall", alu_stall, e_stall);
      chk("model mem_ready", mem_ready, e_ready);
    end
    if (r) begin
      q.delete(); lost = 0; m_busy = '0; m_en = 0; m_rd = '0; m_data = '0;
    end else begin
      if (bturn) begin
        e = q.pop_front();
        m_en = 1; m_rd = e.rd; m_data = e.data; m_busy[e.rd] = 1'b0; lost = 0;
      end else if (areq) begin
        m_en = 1; m_rd = ard; m_data = ad;
        lost = (q.size() > 0) ? ((lost < STARVE) ? lost + 1 : STARVE) : 0;
      end else begin
        m_en = 0; lost = 0;
      end
      if (mv && e_ready && mrd != 0) q.push_back('{rd: mrd, data: md});
      if (iv && ird != 0) m_busy[ird] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (use_model) begin
      chk("model en_write", en_write, m_en);
      chk("model reg_w", reg_w, m_rd);
      chk("model data_in", data_in, m_data);
      chk("model busy", busy, m_busy);
    end
  endtask

  typedef struct {
    logic rst; logic av; logic [4:0] ard; logic [63:0] ad;
    logic mv; logic [4:0] mrd; logic [63:0] md; logic iv; logic [4:0] ird;
    logic stall; logic ready; logic en; logic [4:0] rd; logic [63:0] data; logic [31:0] busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int waited;
    //            rst av ard adata    mv mrd mdata   iv ird | stall ready en rd data     busy
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   0, 0,   0, 1, 0, 0,  64'h0,    32'h0});
    tbl.push_back('{0, 1, 5,  64'hDEAD, 0, 0,  64'h0,   0, 0,   0, 1, 1, 5,  64'hDEAD, 32'h0});
    tbl.push_back('{0, 1, 0,  64'h77,   0, 0,  64'h0,   0, 0,   0, 1, 0, 5,  64'hDEAD, 32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   1, 7,   0, 1, 0, 5,  64'hDEAD, 32'h80});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   1, 0,   0, 1, 0, 5,  64'hDEAD, 32'h80});
    tbl.push_back('{0, 0, 0,  64'h0,    1, 7,  64'h1234,0, 0,   0, 1, 0, 5,  64'hDEAD, 32'h80});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   0, 0,   0, 1, 1, 7,  64'h1234, 32'h0});
    tbl.push_back('{0, 1, 1,  64'hA1,   1, 3,  64'h33,  0, 0,   0, 1, 1, 1,  64'hA1,   32'h0});
    tbl.push_back('{0, 1, 2,  64'hA2,   1, 4,  64'h44,  0, 0,   0, 1, 1, 2,  64'hA2,   32'h0});
    tbl.push_back('{0, 1, 6,  64'hA6,   1, 8,  64'h88,  0, 0,   0, 0, 1, 6,  64'hA6,   32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    1, 8,  64'h88,  0, 0,   0, 0, 1, 3,  64'h33,   32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    1, 8,  64'h88,  0, 0,   0, 1, 1, 4,  64'h44,   32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   0, 0,   0, 1, 1, 8,  64'h88,   32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   0, 0,   0, 1, 0, 8,  64'h88,   32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    1, 10, 64'hB0,  0, 0,   0, 1, 0, 8,  64'h88,   32'h0});
    tbl.push_back('{0, 1, 11, 64'hC1,   0, 0,  64'h0,   0, 0,   0, 1, 1, 11, 64'hC1,   32'h0});
    tbl.push_back('{0, 1, 12, 64'hC2,   0, 0,  64'h0,   0, 0,   0, 1, 1, 12, 64'hC2,   32'h0});
    tbl.push_back('{0, 1, 13, 64'hC3,   0, 0,  64'h0,   0, 0,   0, 1, 1, 13, 64'hC3,   32'h0});
    tbl.push_back('{0, 1, 14, 64'hC4,   0, 0,  64'h0,   0, 0,   0, 1, 1, 14, 64'hC4,   32'h0});
    tbl.push_back('{0, 1, 15, 64'hC5,   0, 0,  64'h0,   0, 0,   1, 1, 1, 10, 64'hB0,   32'h0});
    tbl.push_back('{0, 1, 15, 64'hC5,   0, 0,  64'h0,   0, 0,   0, 1, 1, 15, 64'hC5,   32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    1, 9,  64'h99,  1, 9,   0, 1, 0, 15, 64'hC5,   32'h200});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   1, 9,   0, 1, 1, 9,  64'h99,   32'h200});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   0, 0,   0, 1, 0, 9,  64'h99,   32'h200});
    tbl.push_back('{0, 1, 1,  64'h1,    1, 20, 64'h20,  0, 0,   0, 1, 1, 1,  64'h1,    32'h200});
    tbl.push_back('{0, 1, 2,  64'h2,    1, 21, 64'h21,  0, 0,   0, 1, 1, 2,  64'h2,    32'h200});
    tbl.push_back('{1, 1, 3,  64'h3,    0, 0,  64'h0,   0, 0,   0, 0, 0, 0,  64'h0,    32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   0, 0,   0, 1, 0, 0,  64'h0,    32'h0});
    tbl.push_back('{0, 0, 0,  64'h0,    0, 0,  64'h0,   0, 0,   0, 1, 0, 0,  64'h0,    32'h0});

    rst = 1; alu_valid = 0; alu_rd = '0; alu_data = '0; mem_valid = 0; mem_rd = '0;
    mem_data = '0; issue_valid = 0; issue_rd = '0;
    q.delete(); lost = 0; m_busy = '0; m_en = 0; m_rd = '0; m_data = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd,
           tbl[i].md, tbl[i].iv, tbl[i].ird, 0);
      chk($sformatf("row%0d alu_stall", i), s_stall, tbl[i].stall);
      chk($sformatf("row%0d mem_ready", i), s_ready, tbl[i].ready);
      chk($sformatf("row%0d en_write", i), en_write, tbl[i].en);
      chk($sformatf("row%0d reg_w", i), reg_w, tbl[i].rd);
      chk($sformatf("row%0d data_in", i), data_in, tbl[i].data);
      chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
    end

    // A third long-latency result offered while the buffer is full must wait
    // until the starved head finally pops, then be accepted the cycle after.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 64'h11, 1, 3, 64'h33, 0, 0, 1);
    step(0, 1, 2, 64'h12, 1, 4, 64'h44, 0, 0, 1);
    waited = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 5'(16 + k), 64'(k), 1, 5, 64'h55, 0, 0, 1);
      if (s_ready) break;
      waited++;
    end
    chk("third_push_wait", waited, 4);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), {$urandom, $urandom},
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), {$urandom, $urandom},
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
